// File: rtl/urv_mem_pkg.sv
// rtl/urv_mem_pkg.sv - shared types for the uRV IM/DM memory arbiter
package urv_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_IM    = 2'd1,
    OWN_LOAD  = 2'd2,
    OWN_STORE = 2'd3
  } owner_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/urv_mem_arbiter.sv
// rtl/urv_mem_arbiter.sv - shares one single-port RAM between uRV fetch and data ports
module urv_mem_arbiter
  import urv_mem_pkg::*;
#(
  parameter  int MEM_SIZE     = 16384,
  parameter  int DM_BURST_MAX = 4,
  localparam int AW           = $clog2(MEM_SIZE)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [31:0]   im_addr_i,
  output logic [31:0]   im_data_o,
  output logic          im_valid_o,
  input  logic [31:0]   dm_addr_i,
  input  logic [31:0]   dm_data_s_i,
  input  logic [3:0]    dm_data_select_i,
  input  logic          dm_store_i,
  input  logic          dm_load_i,
  output logic          dm_ready_o,
  output logic [31:0]   dm_data_l_o,
  output logic          dm_load_done_o,
  output logic          dm_store_done_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [31:0]   ram_wdata_o,
  output logic [3:0]    ram_we_o,
  output logic          ram_en_o,
  input  logic [31:0]   ram_rdata_i
);

  owner_t             owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        im_hold_q, dl_hold_q;
  logic               dm_req, force_im, grant_dm, grant_store;

  assign dm_req      = dm_load_i | dm_store_i;
  assign force_im    = (cnt_q == CNT_W'(DM_BURST_MAX));
  assign grant_dm    = dm_req & ~force_im;
  // Store wins over a simultaneous (illegal) load.
  assign grant_store = grant_dm & dm_store_i;
  assign dm_ready_o  = ~force_im;

  always_comb begin
    owner_d = OWN_IM;
    cnt_d   = '0;
    if (grant_dm) begin
      owner_d = dm_store_i ? OWN_STORE : OWN_LOAD;
      cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
  end

  assign ram_en_o    = 1'b1;
  assign ram_addr_o  = grant_dm ? dm_addr_i[AW+1:2] : im_addr_i[AW+1:2];
  assign ram_we_o    = grant_store ? dm_data_select_i : 4'b0000;
  assign ram_wdata_o = dm_data_s_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner_q   <= OWN_NONE;
      cnt_q     <= '0;
      im_hold_q <= '0;
      dl_hold_q <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      if (owner_q == OWN_IM)   im_hold_q <= ram_rdata_i;
      if (owner_q == OWN_LOAD) dl_hold_q <= ram_rdata_i;
    end
  end

  // Responses come straight from the RAM in the cycle after the grant; holds keep the last word.
  assign im_valid_o      = (owner_q == OWN_IM);
  assign im_data_o       = im_valid_o ? ram_rdata_i : im_hold_q;
  assign dm_load_done_o  = (owner_q == OWN_LOAD);
  assign dm_data_l_o     = dm_load_done_o ? ram_rdata_i : dl_hold_q;
  assign dm_store_done_o = (owner_q == OWN_STORE);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{im_addr_i[31:AW+2], im_addr_i[1:0], dm_addr_i[31:AW+2], dm_addr_i[1:0]};

  a_load_store_excl: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(dm_load_i && dm_store_i));

endmodule
